// File: rtl/router_output_arbiter_if.sv
// Handshake bundle between the input-port requesters and one output-port arbiter.
// The arbiter takes the slave modport and the requesters/downstream side take the master modport.
interface router_output_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int PKT_W   = 64
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*PKT_W-1:0] pkt_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     ro;
  logic                     so;
  logic [PKT_W-1:0]         pkt_out;
  logic                     busy;

  modport master (output req, pkt_in, ro, input gnt, so, pkt_out, busy);
  modport slave  (input req, pkt_in, ro, output gnt, so, pkt_out, busy);
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin arbiter with a single-entry output buffer for one router output port.
// Define ROUTER_ARB_STATS_EN to add saturating per-requester grant counters and a stall counter.
module router_output_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int PKT_W   = 64,
  parameter int PTR_W   = 3
) (
  input  logic clk,
  input  logic reset,
  router_output_arbiter_if.slave bus
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t               state_r;
  logic                 so_r;
  logic                 busy_r;
  logic [PKT_W-1:0]     pkt_out_r;
  logic [PTR_W-1:0]     ptr_r;

  logic                 drain_s;
  logic                 accept_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic [PTR_W-1:0]     ptr_nxt_s;
  logic [PKT_W-1:0]     pkt_sel_s;

  // First requester at or after the pointer, wrapping around; the result is one-hot or zero.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                                 input logic [PTR_W-1:0]   ptr_v);
    logic [NUM_REQ-1:0] g;
    logic               found;
    logic [PTR_W-1:0]   idx;
    g     = {NUM_REQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx    = PTR_W'((int'(ptr_v) + k) % NUM_REQ);
      g[idx] = req_v[idx] & ~found;
      found  = found | req_v[idx];
    end
    return g;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] g);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = idx | (g[k] ? PTR_W'(k) : {PTR_W{1'b0}});
    end
    return idx;
  endfunction

  // Grant decision: the buffer accepts when empty or when it drains in the same cycle.
  always_comb begin
    drain_s   = (state_r == ST_FULL) & bus.ro;
    accept_s  = 1'b0;
    gnt_s     = {NUM_REQ{1'b0}};
    pkt_sel_s = {PKT_W{1'b0}};
    if (reset) begin
      accept_s = 1'b0;
    end else begin
      accept_s = (|bus.req) & ((state_r == ST_EMPTY) | drain_s);
    end
    if (accept_s) begin
      gnt_s = rr_pick(bus.req, ptr_r);
    end else begin
      gnt_s = {NUM_REQ{1'b0}};
    end
    gnt_idx_s = onehot_idx(gnt_s);
    for (int k = 0; k < NUM_REQ; k++) begin
      pkt_sel_s = pkt_sel_s | ({PKT_W{gnt_s[k]}} & bus.pkt_in[k*PKT_W +: PKT_W]);
    end
    if (gnt_idx_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      ptr_nxt_s = gnt_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  // Output buffer state machine and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_EMPTY;
      so_r      <= 1'b0;
      busy_r    <= 1'b0;
      pkt_out_r <= {PKT_W{1'b0}};
      ptr_r     <= {PTR_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r   <= ST_FULL;
            so_r      <= 1'b1;
            busy_r    <= 1'b1;
            pkt_out_r <= pkt_sel_s;
            ptr_r     <= ptr_nxt_s;
          end
        end
        ST_FULL: begin
          if (accept_s) begin
            pkt_out_r <= pkt_sel_s;
            ptr_r     <= ptr_nxt_s;
          end else if (bus.ro) begin
            // pkt_out keeps its stale value; so=0 marks it invalid.
            state_r <= ST_EMPTY;
            so_r    <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          so_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_s;
  assign bus.so      = so_r;
  assign bus.busy    = busy_r;
  assign bus.pkt_out = pkt_out_r;

`ifdef ROUTER_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_r;
  logic [15:0]              stall_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Per-requester grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        grant_cnt_r[k] <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        grant_cnt_r[k] <= sat_inc(grant_cnt_r[k], gnt_s[k]);
      end
    end
  end

  // Cycles where a valid output is blocked by downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else begin
      stall_cnt_r <= sat_inc(stall_cnt_r, (state_r == ST_FULL) & ~bus.ro);
    end
  end

  assign grant_cnt = grant_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed vector bench for router_output_arbiter; stats checks run when ROUTER_ARB_STATS_EN is defined.
module tb_router_output_arbiter;

  localparam int NUM_REQ = 5;
  localparam int PKT_W   = 64;
  localparam int PTR_W   = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  router_output_arbiter_if #(.NUM_REQ(NUM_REQ), .PKT_W(PKT_W)) bus ();

`ifdef ROUTER_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  router_output_arbiter #(.NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic [4:0]       req;
    logic             ro;
    logic [4:0]       gnt;
    logic             so;
    logic [63:0]      pkt;
    logic [2:0]       ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  function automatic void add(input logic rst, input logic [4:0] req, input logic ro,
                              input logic [4:0] gnt, input logic so,
                              input logic [63:0] pkt, input logic [2:0] ptr);
    vec_t v;
    v.rst = rst; v.req = req; v.ro = ro; v.gnt = gnt; v.so = so; v.pkt = pkt; v.ptr = ptr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // gnt is checked before the edge, registered outputs just after it.
  task automatic run_vec(input int n, input vec_t v);
    reset  = v.rst;
    bus.req = v.req;
    bus.ro  = v.ro;
    #1;
    chk($sformatf("v%0d gnt", n), 64'(bus.gnt), 64'(v.gnt));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d so", n), 64'(bus.so), 64'(v.so));
    chk($sformatf("v%0d busy", n), 64'(bus.busy), 64'(v.so));
    chk($sformatf("v%0d pkt_out", n), bus.pkt_out, v.pkt);
    chk($sformatf("v%0d ptr", n), 64'(dut.ptr_r), 64'(v.ptr));
  endtask

  initial begin
    int bubbles;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req = 5'b00000;
    bus.ro  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bus.pkt_in[i*PKT_W +: PKT_W] = pk(i);

    //   rst  req       ro    gnt       so    pkt        ptr
    add(1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 64'h0,     3'd0);
    add(1'b0, 5'b00100, 1'b1, 5'b00100, 1'b1, pk(2),     3'd3);
    add(1'b1, 5'b00000, 1'b1, 5'b00000, 1'b0, 64'h0,     3'd0);
    for (int i = 0; i < 10; i++)
      add(1'b0, 5'b11111, 1'b1, 5'(1 << (i % 5)), 1'b1, pk(i % 5), 3'((i % 5 + 1) % 5));
    add(1'b0, 5'b10001, 1'b1, 5'b00001, 1'b1, pk(0),     3'd1);
    add(1'b0, 5'b10001, 1'b1, 5'b10000, 1'b1, pk(4),     3'd0);
    add(1'b0, 5'b10001, 1'b1, 5'b00001, 1'b1, pk(0),     3'd1);
    for (int i = 0; i < 4; i++)
      add(1'b0, 5'b00010, 1'b0, 5'b00000, 1'b1, pk(0),   3'd1);
    add(1'b0, 5'b00010, 1'b1, 5'b00010, 1'b1, pk(1),     3'd2);
    add(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, pk(1),     3'd2);
    add(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, pk(1),     3'd2);
    add(1'b0, 5'b01000, 1'b0, 5'b01000, 1'b1, pk(3),     3'd4);
    add(1'b0, 5'b11111, 1'b0, 5'b00000, 1'b1, pk(3),     3'd4);
    add(1'b1, 5'b11111, 1'b0, 5'b00000, 1'b0, 64'h0,     3'd0);
    add(1'b0, 5'b00000, 1'b0, 5'b00000, 1'b0, 64'h0,     3'd0);

    for (int n = 0; n < vecs.size(); n++) run_vec(n, vecs[n]);

    // Back-to-back throughput: once full, so must never drop while ro=1 and requests persist.
    reset = 1'b0; bus.req = 5'b11111; bus.ro = 1'b1;
    @(posedge clk); #1;
    bubbles = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.so !== 1'b1) bubbles++;
      @(posedge clk); #1;
    end
    chk("throughput bubbles", 64'(bubbles), 64'd0);
    bus.req = 5'b00000;
    @(posedge clk); #1;
    chk("drain to empty so", 64'(bus.so), 64'd0);

`ifdef ROUTER_ARB_STATS_EN
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0;
    bus.req = 5'b00010; bus.ro = 1'b0;
    @(posedge clk); #1;
    bus.req = 5'b00000;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    bus.req = 5'b00010; bus.ro = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = 5'b00000;
    @(posedge clk); #1;
    chk("grant_cnt[1]", 64'(grant_cnt[16 +: 16]), 64'd3);
    chk("grant_cnt[0]", 64'(grant_cnt[0 +: 16]), 64'd0);
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
    bus.req = 5'b00001; bus.ro = 1'b0;
    @(posedge clk); #1;
    bus.req = 5'b00000;
    force dut.stall_cnt_r = 16'hFFFE;
    @(posedge clk); #1;
    release dut.stall_cnt_r;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("stall_cnt saturate", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Round-robin arbiter and single-entry output stage for one router output port.
- Shares the port among NUM_REQ input requesters; default order is 0=E, 1=W, 2=S, 3=N, 4=PE.
- Downstream handshake matches the router's so/ro convention:
  - so: output valid.
  - ro: downstream ready.
- One instance per output direction; a router top instantiates five.

Parameters:
- NUM_REQ, 5, number of requesting input ports (2..8).
- PKT_W, 64, packet width in bits.
- PTR_W, 3, width of the round-robin pointer; must satisfy 2^PTR_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; bit i means input i holds a packet for this output.
- pkt_in  input  NUM_REQ*PKT_W  flattened packets; requester i occupies bits [i*PKT_W +: PKT_W].
- gnt  output  NUM_REQ  one-hot grant, combinational. Requester i's packet is consumed at the clock edge where gnt[i]=1.
- ro  input  1  downstream ready.
- so  output  1  output valid (buffer full).
- pkt_out  output  PKT_W  registered output packet.
- busy  output  1  registered; equals so.

Behaviour:
- Reset values (synchronous on reset=1):
  - state=EMPTY, so=0, busy=0, pkt_out=0, ptr=0.
  - gnt forced to 0 while reset=1.
- State machine:
  - EMPTY: so=0.
  - FULL: so=1, pkt_out valid.
- drain = FULL && ro.
- accept = (|req) && (EMPTY || drain).
- Grant selection:
  - gnt is nonzero only when accept=1.
  - Exactly one bit is set: the first requesting index found scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- Transitions at each clock edge:
  - EMPTY, no req: stay EMPTY.
  - EMPTY, req: load the granted packet into pkt_out; go to FULL.
  - FULL, ro=0: hold; pkt_out stable; gnt=0.
  - FULL, ro=1, no req: go to EMPTY. pkt_out keeps its last value; so=0 marks it invalid.
  - FULL, ro=1, req: drain and load in the same cycle; stay FULL; pkt_out takes the new packet on the next cycle. No bubble.
- Pointer:
  - On accept, ptr <= (granted index + 1) mod NUM_REQ, so the just-granted requester gets lowest priority.
  - ptr is unchanged when there is no accept.
  - Wrap: grant index NUM_REQ-1 sets ptr to 0.
- Latency:
  - Packet appears on pkt_out with so=1 one cycle after its grant.
  - Sustained throughput is one packet per cycle while ro=1.
- Fairness: with all requests held high, grants rotate 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 accepts.
- ro is sampled only in FULL; ro while EMPTY has no effect.
- Requesters must hold req and pkt_in stable until granted. A req deasserted before its grant is simply never served.
- Reset mid-operation: a buffered packet is discarded and so drops on the next edge. No grant is issued in the reset cycle.
- No combinational path from ro to so or pkt_out. gnt depends combinationally on req, ro, state and ptr.

Optional Feature:
- Macro: ROUTER_ARB_STATS_EN.
- With the macro defined:
  - Extra output grant_cnt, NUM_REQ*16 bits: per-requester saturating 16-bit counters.
  - Counter i increments on every clock edge with gnt[i]=1, saturates at 16'hFFFF, and clears on reset.
  - Extra output stall_cnt, 16 bits: saturating count of cycles with FULL && ro=0; clears on reset.
- Without it: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then req=5'b00100 with pkt_in[2]=64'hA5A5_0000_0000_0002 and ro=1 → gnt=5'b00100 in cycle 0. Next cycle so=1, pkt_out=64'hA5A5_0000_0000_0002, ptr=3.
- req=5'b11111 held, ro=1 for 10 cycles → grant sequence 0,1,2,3,4,0,1,2,3,4. so stays 1 from cycle 1 with no bubbles.
- Load one packet, then ro=0 for 4 cycles with req=5'b00010 → gnt=0 and pkt_out stable for all 4 cycles. Raising ro gives gnt=5'b00010 in that same cycle, and the new packet appears next cycle.
- Wrap: grant index 4, then req=5'b10001 → index 0 is granted before 4.
- Reset asserted while FULL with ro=0 → next cycle so=0, pkt_out=0, ptr=0. gnt=0 during the reset cycle even with req=5'b11111.
- With ROUTER_ARB_STATS_EN: 3 grants to index 1 and 5 stall cycles → grant_cnt[1]=3, stall_cnt=5. Preload a counter near 16'hFFFF (force) and confirm it saturates rather than wrapping.
